// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states and handshake levels.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU. Works on operand magnitudes and
// fixes the signs of quotient and remainder on the finalize edge.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// DIV_FREE   | idle, waiting for start without annul
// DIV_BYZERO | divisor was zero; next edge publishes a zero result
// DIV_ON     | iterating one quotient bit per edge, then finalizing
// DIV_END    | result valid; held until EX drops start
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

  localparam int CW = $clog2(DW) + 1;

  div_state_e      r_state;
  div_state_e      w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [2*DW:0]   r_dividend;
  logic [DW-1:0]   r_divisor;
  logic            r_neg1;
  logic            r_neg2;

  logic            w_accept;
  logic            w_last;
  logic [DW-1:0]   w_mag1;
  logic [DW-1:0]   w_mag2;
  logic [DW:0]     w_diff;
  logic [DW-1:0]   w_quo;
  logic [DW-1:0]   w_rem;

  // Operand magnitudes; the most negative value keeps its bit pattern, which
  // is exactly its magnitude when read as unsigned.
  always_comb begin
    w_accept = (start_i == DIV_START) && !annul_i;
    w_last   = (r_cnt == CW'(DW));
    w_mag1   = (signed_div_i && opdata1_i[DW-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    w_mag2   = (signed_div_i && opdata2_i[DW-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    w_diff   = {1'b0, r_dividend[2*DW-1:DW]} - {1'b0, r_divisor};
    w_quo    = (r_neg1 ^ r_neg2) ? (~r_dividend[DW-1:0] + 1'b1) : r_dividend[DW-1:0];
    w_rem    = r_neg1 ? (~r_dividend[2*DW:DW+1] + 1'b1) : r_dividend[2*DW:DW+1];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= DIV_FREE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode; annul wins over the finalize edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_FREE: begin
        if (w_accept) w_state_nxt = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
      end
      DIV_BYZERO: w_state_nxt = DIV_END;
      DIV_ON: begin
        if (annul_i)     w_state_nxt = DIV_FREE;
        else if (w_last) w_state_nxt = DIV_END;
      end
      DIV_END: begin
        if (start_i == DIV_STOP) w_state_nxt = DIV_FREE;
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_neg1     <= 1'b0;
      r_neg2     <= 1'b0;
      result_o   <= '0;
      ready_o    <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (w_accept) begin
            r_cnt      <= '0;
            r_divisor  <= w_mag2;
            r_dividend <= {{DW{1'b0}}, w_mag1, 1'b0};
            r_neg1     <= signed_div_i & opdata1_i[DW-1];
            r_neg2     <= signed_div_i & opdata2_i[DW-1];
          end
        end
        DIV_BYZERO: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (annul_i) begin
            r_cnt    <= '0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end else if (!w_last) begin
            if (w_diff[DW]) r_dividend <= {r_dividend[2*DW-1:0], 1'b0};
            else            r_dividend <= {w_diff[DW-1:0], r_dividend[DW-1:0], 1'b1};
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt    <= '0;
            result_o <= {w_rem, w_quo};
            ready_o  <= DIV_RESULT_READY;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// operands compared against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_unit #(.DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  // Reference: divide magnitudes, quotient negative when signs differ,
  // remainder follows the dividend's sign, zero divisor gives zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic        na, nb;
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    na = s & a[31];
    nb = s & b[31];
    ma = na ? (~a + 32'd1) : a;
    mb = nb ? (~b + 32'd1) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = ~q + 32'd1;
    if (na)      r = ~r + 32'd1;
    return {r, q};
  endfunction

  // Runs one full handshake: start, wait for ready (bounded), hold start for
  // three more cycles, then drop start. Operands are scrambled after accept.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] res, output int lat,
                        output logic [63:0] res_hold, output logic rdy_hold,
                        output logic [63:0] res_after, output logic rdy_after);
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1'b1; annul_i = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
      end
    end while (!ready_o && lat < 100);
    res = result_o;
    repeat (3) @(negedge clk);
    res_hold = result_o;
    rdy_hold = ready_o;
    start_i = 1'b0;
    @(negedge clk);
    res_after = result_o;
    rdy_after = ready_o;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    n_cmp++;
    if (result_o !== 64'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_o); end
    start_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL idle_ready: got %b want 0", ready_o); end
  endtask

  task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic s);
    logic [63:0] res, res_hold, res_after, exp;
    logic        rdy_hold, rdy_after;
    int          lat, exp_lat;
    exp     = ref_div(a, b, s);
    exp_lat = (b == 32'd0) ? 2 : 34;
    do_div(a, b, s, res, lat, res_hold, rdy_hold, res_after, rdy_after);
    n_cmp++;
    if (lat !== exp_lat) begin n_bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); end
    n_cmp++;
    if (res !== exp) begin n_bad++; $display("FAIL %s_result: got %h want %h", name, res, exp); end
    n_cmp++;
    if (res_hold !== exp) begin n_bad++; $display("FAIL %s_hold_result: got %h want %h", name, res_hold, exp); end
    n_cmp++;
    if (rdy_hold !== 1'b1) begin n_bad++; $display("FAIL %s_hold_ready: got %b want 1", name, rdy_hold); end
    n_cmp++;
    if (rdy_after !== 1'b0) begin n_bad++; $display("FAIL %s_drop_ready: got %b want 0", name, rdy_after); end
    n_cmp++;
    if (res_after !== 64'd0) begin n_bad++; $display("FAIL %s_drop_result: got %h want 0", name, res_after); end
  endtask

  task automatic test_annul_restart();
    logic [63:0] res, res_hold, res_after, exp;
    logic        rdy_hold, rdy_after, seen;
    int          lat;
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);                    // E0 accepts
    repeat (9) @(posedge clk);         // E1..E9
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);                    // E10 annuls
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL annul_ready: got %b want 0", ready_o); end
    n_cmp++;
    if (result_o !== 64'd0) begin n_bad++; $display("FAIL annul_result: got %h want 0", result_o); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ready_o) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL annul_no_ready: got %b want 0", seen); end
    // start with annul held must not be accepted
    start_i = 1'b1; annul_i = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ready_o) seen = 1'b1; end
    start_i = 1'b0; annul_i = 1'b0;
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL annul_start_ignored: got %b want 0", seen); end
    exp = ref_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, res, lat, res_hold, rdy_hold, res_after, rdy_after);
    n_cmp++;
    if (lat !== 34) begin n_bad++; $display("FAIL restart_latency: got %0d want 34", lat); end
    n_cmp++;
    if (res !== exp) begin n_bad++; $display("FAIL restart_result: got %h want %h", res, exp); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);                    // E0
    repeat (19) @(posedge clk);        // E1..E19
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);                    // E20 resets
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", ready_o); end
    n_cmp++;
    if (result_o !== 64'd0) begin n_bad++; $display("FAIL midrst_result: got %h want 0", result_o); end
    rst = 1'b1; start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ready_o) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_ready: got %b want 0", seen); end
    test_directed("after_rst_100_7", 32'd100, 32'd7, 1'b0);
  endtask

  task automatic test_random(input int n);
    logic [63:0] res, res_hold, res_after, exp;
    logic        rdy_hold, rdy_after, s;
    logic [31:0] a, b;
    int          lat, exp_lat;
    for (int i = 0; i < n; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 1000));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = ~32'($urandom_range(0, 14));
        default: b = $urandom;
      endcase
      exp     = ref_div(a, b, s);
      exp_lat = (b == 32'd0) ? 2 : 34;
      do_div(a, b, s, res, lat, res_hold, rdy_hold, res_after, rdy_after);
      n_cmp++;
      if (res !== exp) begin
        n_bad++;
        $display("FAIL rand%0d_result: a=%h b=%h s=%b got %h want %h", i, a, b, s, res, exp);
      end
      n_cmp++;
      if (lat !== exp_lat) begin n_bad++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, exp_lat); end
      n_cmp++;
      if (rdy_after !== 1'b0) begin n_bad++; $display("FAIL rand%0d_drop_ready: got %b want 0", i, rdy_after); end
    end
  endtask

  initial begin
    test_reset();
    test_directed("udiv_100_7", 32'h64, 32'h7, 1'b0);
    test_directed("sdiv_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1);
    test_directed("div_by_zero", 32'h1234, 32'h0, 1'b0);
    test_directed("sdiv_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    test_directed("udiv_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    test_annul_restart();
    test_reset_mid();
    test_random(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider that EX sequences for DIV/DIVU.
- EX drives the divider's operands, sign flag and start, and holds start high while stalling the pipeline.
- The divider returns {remainder, quotient} and a ready pulse-level flag; EX writes the result to HI/LO.
- Contains the sequencing FSM, iteration counter, operand/result registers, sign pre/post-correction and annul handling.

Parameters:
- DW, 32, operand width.
- The counter is $clog2(DW)+1 bits wide.
- The result is 2*DW bits wide.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low (rst=0 resets on the rising clk edge).
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  input  DW  dividend.
- opdata2_i  input  DW  divisor.
- start_i  input  1  request; EX holds it high until ready_o is seen.
- annul_i  input  1  abort current division (pipeline flush).
- result_o  output  2*DW  {remainder[63:32], quotient[31:0]}.
- ready_o  output  1  result valid.

Behaviour:
- States (2-bit): FREE, BYZERO, ON, END. Edge names below: E0 is the edge that accepts start in FREE.
- Reset (rst=0 at any edge, any state, including mid-ON):
  - state goes to FREE.
  - result_o = 0 and ready_o = 0.
  - Counter and working register are cleared.
- FREE:
  - ready_o = 0 and result_o = 0.
  - On start_i=1 and annul_i=0, operands and sign are latched. Later operand changes are ignored.
  - If opdata2_i == 0, go to BYZERO.
  - Otherwise go to ON with cnt = 0.
  - When signed and an operand is negative, the latched value is its two's complement magnitude. 0x80000000 maps to magnitude 0x80000000, unsigned.
  - Working register dividend[2*DW:0] is loaded with the magnitude of op1 at bits [DW:1] and zeros elsewhere.
  - start_i with annul_i=1 is ignored.
- BYZERO: next edge goes to END with result_o = 0 and ready_o = 1.
- ON, one iteration per edge while annul_i = 0 and cnt < DW:
  - diff = {1'b0, dividend[2*DW-1:DW]} − {1'b0, divisor}.
  - If diff[DW] is 1, dividend <<= 1.
  - Otherwise dividend = {diff[DW-1:0], dividend[DW-1:0], 1'b1}.
  - cnt increments.
- ON, final edge (cnt == DW):
  - Quotient = dividend[DW-1:0]. Remainder = dividend[2*DW:DW+1].
  - If signed and op1 sign ≠ op2 sign, the quotient is negated.
  - If signed and op1 is negative, the remainder is negated (remainder takes the dividend's sign).
  - Register result_o = {rem, quo}, set ready_o = 1, go to END.
- ON, annul_i=1 at any edge: go to FREE. ready_o stays 0, result_o = 0, no result produced.
- ON, start_i is ignored.
- Latency: ready_o is high after E33 for non-zero divisor (1 accept + 32 iterations + 1 finalize), and after E1 for a zero divisor.
- END:
  - ready_o and result_o hold while start_i = 1.
  - The first edge with start_i = 0 returns to FREE with ready_o = 0 and result_o = 0.
  - A new division needs at least one cycle with start_i low.
- annul_i in END is ignored; EX drops start.
- Signed overflow (−2^31 / −1) yields quotient 0x80000000 and remainder 0. No trap.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Into the shared defines.v:
  - state encodings DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivStart/DivStop (1/0).
  - DivResultReady/DivResultNotReady (1/0).
  - DoubleRegBus and zeroword already exist.
- No sub-module is natural. The subtract step is a single expression, and the block stays as one module.

Test Plan:
- Unsigned 100/7: start, op1 = 0x64, op2 = 0x7, signed = 0 → ready_o rises after E33, result_o = {0x00000002, 0x0000000E}. Drop start → ready_o = 0, result_o = 0 next edge.
- Signed −7/2: op1 = 0xFFFFFFF9, op2 = 0x2, signed = 1 → result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
- Divide by zero: op1 = 0x1234, op2 = 0 → ready_o = 1 after E1, result_o = 0. State stays END while start is held.
- Annul then restart:
  - Start 0x64/0x7, assert annul_i at the 10th iteration edge → FREE, ready_o never rises.
  - Restart unsigned 0xFFFFFFFF/1 → result_o = {0, 0xFFFFFFFF} after E33.
- Signed overflow: op1 = 0x80000000, op2 = 0xFFFFFFFF, signed = 1 → result_o = {0x00000000, 0x80000000}.
- Reset mid-op: rst = 0 at the 20th iteration edge → ready_o = 0 and result_o = 0. A following 0x64/0x7 run completes normally with the correct result.
